// File: rtl/chr_tile_fetcher.sv
// CHR pattern-row fetcher: reads the lo/hi bitplane bytes of one tile row, then shifts out eight 2-bit pixels.
// Optional feature macro: CHR_FETCH_HFLIP_EN adds an hflip input that emits the row LSB first.
module chr_tile_fetcher #(
   parameter int AW = 16,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req,
   input  logic          table_sel,
   input  logic [7:0]    tile_idx,
   input  logic [2:0]    fine_y,
`ifdef CHR_FETCH_HFLIP_EN
   input  logic          hflip,
`endif
   output logic          busy,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          pix_valid,
   output logic [1:0]    pix,
   output logic          done,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD_LO = 2'd1,
      S_RD_HI = 2'd2,
      S_SHIFT = 2'd3
   } state_t;

   state_t r_state;
   state_t w_next;

   logic          r_busy;
   logic [AW-1:0] r_addr;
   logic          r_pv;
   logic [1:0]    r_pix;
   logic          r_done;
   logic          r_table;
   logic [7:0]    r_tile;
   logic [2:0]    r_fy;
   logic [7:0]    r_lo;
   logic [7:0]    r_sh_lo;
   logic [7:0]    r_sh_hi;
   logic [2:0]    r_cnt;

   logic          w_flip;
   logic          w_last;
   logic          w_accept;
   logic          w_lat_lo;
   logic          w_load;
   logic          w_shift;
   logic          w_end;
   logic [7:0]    w_src_hi;
   logic [7:0]    w_src_lo;
   logic [1:0]    w_out_bits;
   logic [7:0]    w_nxt_hi;
   logic [7:0]    w_nxt_lo;
   logic [AW-1:0] w_lo_addr;
   logic [AW-1:0] w_hi_addr;

`ifdef CHR_FETCH_HFLIP_EN
   logic r_flip;
   assign w_flip = r_flip;
`else
   assign w_flip = 1'b0;
`endif

   assign w_last    = (r_state == S_SHIFT) && (r_cnt == 3'd7);
   assign w_lo_addr = {{(AW-13){1'b0}}, table_sel, tile_idx, 1'b0, fine_y};
   assign w_hi_addr = {{(AW-13){1'b0}}, r_table, r_tile, 1'b1, r_fy};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic; the final SHIFT edge doubles as an accept point so held req gives a 10-cycle period
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next = S_RD_LO;
         S_RD_LO: w_next = S_RD_HI;
         S_RD_HI: w_next = S_SHIFT;
         S_SHIFT: if (r_cnt == 3'd7) w_next = req ? S_RD_LO : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Output / datapath control decode
   always_comb begin
      w_accept = req && ((r_state == S_IDLE) || w_last);
      w_lat_lo = (r_state == S_RD_LO);
      w_load   = (r_state == S_RD_HI);
      w_shift  = (r_state == S_SHIFT) && !w_last;
      w_end    = w_last && !req;
      w_src_hi = w_load ? mem_rdata[7:0] : r_sh_hi;
      w_src_lo = w_load ? r_lo : r_sh_lo;
      if (w_flip) begin
         w_out_bits = {w_src_hi[0], w_src_lo[0]};
         w_nxt_hi   = w_src_hi >> 1;
         w_nxt_lo   = w_src_lo >> 1;
      end else begin
         w_out_bits = {w_src_hi[7], w_src_lo[7]};
         w_nxt_hi   = w_src_hi << 1;
         w_nxt_lo   = w_src_lo << 1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy  <= 1'b0;
         r_addr  <= '0;
         r_pv    <= 1'b0;
         r_pix   <= 2'd0;
         r_done  <= 1'b0;
         r_table <= 1'b0;
         r_tile  <= 8'd0;
         r_fy    <= 3'd0;
         r_lo    <= 8'd0;
         r_sh_lo <= 8'd0;
         r_sh_hi <= 8'd0;
         r_cnt   <= 3'd0;
`ifdef CHR_FETCH_HFLIP_EN
         r_flip  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_table <= table_sel;
         r_tile  <= tile_idx;
         r_fy    <= fine_y;
`ifdef CHR_FETCH_HFLIP_EN
         r_flip  <= hflip;
`endif
         r_addr  <= w_lo_addr;
         r_busy  <= 1'b1;
         r_pv    <= 1'b0;
         r_pix   <= 2'd0;
         r_done  <= 1'b0;
      end else if (w_lat_lo) begin
         r_lo   <= mem_rdata[7:0];
         r_addr <= w_hi_addr;
      end else if (w_load) begin
         r_pix   <= w_out_bits;
         r_sh_hi <= w_nxt_hi;
         r_sh_lo <= w_nxt_lo;
         r_cnt   <= 3'd0;
         r_pv    <= 1'b1;
      end else if (w_shift) begin
         r_pix   <= w_out_bits;
         r_sh_hi <= w_nxt_hi;
         r_sh_lo <= w_nxt_lo;
         r_cnt   <= r_cnt + 3'd1;
         r_done  <= (r_cnt == 3'd6);
      end else if (w_end) begin
         r_busy <= 1'b0;
         r_pv   <= 1'b0;
         r_pix  <= 2'd0;
         r_done <= 1'b0;
      end
   end

   assign busy      = r_busy;
   assign mem_addr  = r_addr;
   assign mem_we    = 1'b0;
   assign mem_wdata = '0;
   assign pix_valid = r_pv;
   assign pix       = r_pix;
   assign done      = r_done;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_chr_tile_fetcher.sv
// Bench for chr_tile_fetcher: negedge-read CHR RAM model plus a cycle-timeline reference model.
// Define CHR_FETCH_HFLIP_EN to build and exercise the hflip variant.
module tb_chr_tile_fetcher;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req;
   logic        table_sel;
   logic [7:0]  tile_idx;
   logic [2:0]  fine_y;
   logic        hflip;
   logic        busy;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        pix_valid;
   logic [1:0]  pix;
   logic        done;
   logic [1:0]  dbg_state;

   chr_tile_fetcher #(.AW(16), .DW(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .table_sel (table_sel),
      .tile_idx  (tile_idx),
      .fine_y    (fine_y),
`ifdef CHR_FETCH_HFLIP_EN
      .hflip     (hflip),
`endif
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .pix_valid (pix_valid),
      .pix       (pix),
      .done      (done),
      .dbg_state (dbg_state)
   );

   // CHR RAM: read on the falling edge, data ready for the next rising edge
   logic [7:0] mem [0:8191];
   always @(negedge clk) mem_rdata <= mem[mem_addr[12:0]];

   // ---------------- scoreboard / model ----------------
   int          checks   = 0;
   int          failures = 0;
   int          t        = 0;   // cycles since the fetch was accepted, 0 = idle
   logic [15:0] m_addr   = 16'd0;
   logic [15:0] m_hi_addr;
   logic [1:0]  exp_q[$];
   logic [15:0] obs_seq;
   int          pv_cnt;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s got=%0h exp=%0h time=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      logic [7:0] lo;
      logic [7:0] hi;
      logic       f;
      if (reset) begin
         t = 0;
         m_addr = 16'd0;
         exp_q.delete();
      end else if (t == 0 || t == 10) begin
         if (req) begin
`ifdef CHR_FETCH_HFLIP_EN
            f = hflip;
`else
            f = 1'b0;
`endif
            m_addr    = {3'b000, table_sel, tile_idx, 1'b0, fine_y};
            m_hi_addr = m_addr + 16'd8;
            lo = mem[m_addr[12:0]];
            hi = mem[m_hi_addr[12:0]];
            exp_q.delete();
            for (int k = 0; k < 8; k++)
               exp_q.push_back(f ? {hi[k], lo[k]} : {hi[7-k], lo[7-k]});
            t = 1;
         end else begin
            t = 0;
         end
      end else begin
         t++;
         if (t == 2) m_addr = m_hi_addr;
      end
   endtask

   task automatic check_outputs();
      logic [1:0] ep;
      ep = 2'd0;
      if (t >= 3) begin
         if (exp_q.size() == 0) check_val("exp_q_empty", 1, 0);
         else ep = exp_q.pop_front();
      end
      check_val("busy",      busy,      (t != 0));
      check_val("mem_addr",  mem_addr,  m_addr);
      check_val("pix_valid", pix_valid, (t >= 3));
      check_val("pix",       pix,       ep);
      check_val("done",      done,      (t == 10));
      check_val("mem_we",    mem_we,    0);
      check_val("mem_wdata", mem_wdata, 0);
      if (pix_valid) begin
         obs_seq = {obs_seq[13:0], pix};
         pv_cnt++;
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic r, input logic ts, input logic [7:0] ti,
                       input logic [2:0] fy, input logic hf);
      req = r; table_sel = ts; tile_idx = ti; fine_y = fy; hflip = hf;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic fetch_and_drain(input logic ts, input logic [7:0] ti,
                                  input logic [2:0] fy, input logic hf);
      obs_seq = 16'd0;
      pv_cnt  = 0;
      step(1'b1, ts, ti, fy, hf);
      for (int i = 0; i < 11; i++)
         step(1'b0, $urandom_range(0, 1), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b0);
   endtask

   initial begin
      for (int a = 0; a < 8192; a++) mem[a] = 8'($urandom_range(0, 255));
      reset = 1'b1; req = 1'b0; table_sel = 1'b0; tile_idx = 8'd0; fine_y = 3'd0; hflip = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_outputs();
      check_val("rst_state", dbg_state, 0);
      reset = 1'b0;
      step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);

      // basic fetch
      mem[13'h0012] = 8'hF0;
      mem[13'h001A] = 8'h3C;
      fetch_and_drain(1'b0, 8'h01, 3'd2, 1'b0);
      check_val("basic_seq", obs_seq, 16'h5FA0);
      check_val("basic_pvcnt", pv_cnt, 8);

`ifdef CHR_FETCH_HFLIP_EN
      fetch_and_drain(1'b0, 8'h01, 3'd2, 1'b1);
      check_val("hflip_seq", obs_seq, 16'h0AF5);
`endif

      // upper address boundary
      mem[13'h1FF7] = 8'hFF;
      mem[13'h1FFF] = 8'h00;
      fetch_and_drain(1'b1, 8'hFF, 3'd7, 1'b0);
      check_val("bound_seq", obs_seq, 16'h5555);

      // req held high: back-to-back fetches every 10 cycles
      pv_cnt = 0;
      for (int i = 0; i < 30; i++)
         step(1'b1, $urandom_range(0, 1), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 1'b0);
      check_val("held_pvcnt", pv_cnt, 24);
      for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);

      // req pulse in the 4th SHIFT cycle is ignored
      pv_cnt = 0;
      step(1'b1, 1'b0, 8'h22, 3'd5, 1'b0);
      for (int i = 0; i < 14; i++) step((t == 6), 1'b1, 8'h77, 3'd1, 1'b0);
      check_val("pulse_pvcnt", pv_cnt, 8);

      // reset during RD_HI
      step(1'b1, 1'b0, 8'h40, 3'd3, 1'b0);
      step(1'b0, 1'b0, 8'h00, 3'd0, 1'b0);
      reset = 1'b1;
      #1;
      t = 0; m_addr = 16'd0; exp_q.delete();
      check_val("midrst_busy", busy, 0);
      check_val("midrst_pv",   pix_valid, 0);
      check_val("midrst_done", done, 0);
      check_val("midrst_addr", mem_addr, 0);
      @(negedge clk);
      step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
      reset = 1'b0;
      step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);
      fetch_and_drain(1'b0, 8'h40, 3'd3, 1'b0);
      check_val("post_rst_pvcnt", pv_cnt, 8);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) == 0), $urandom_range(0, 1), 8'($urandom_range(0, 255)),
              3'($urandom_range(0, 7)), $urandom_range(0, 1));
      for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 8'd0, 3'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
